// File: rtl/dp64_multiprecision_pkg.sv
// Shared widths for the 64-bit multi-precision dot-product unit.
// Holds the operand width, the four output widths and the result bundle.
package dp64_multiprecision_pkg;

  localparam int DATA_W  = 64;
  localparam int SUM16_W = 35;
  localparam int SUM8_W  = 19;
  localparam int SUM4_W  = 12;
  localparam int SUM2_W  = 11;

  typedef struct packed {
    logic [SUM16_W-1:0] s16;
    logic [SUM8_W-1:0]  s8;
    logic [SUM4_W-1:0]  s4;
    logic [SUM2_W-1:0]  s2;
  } sums_t;

endpackage

// File: rtl/dp64_multiprecision_if.sv
// Operand/result bundle for dp64_multiprecision (no handshake).
// master: drives a, b; reads the four sums. slave: the reverse.
interface dp64_multiprecision_if;
  import dp64_multiprecision_pkg::*;

  logic [DATA_W-1:0]  a;
  logic [DATA_W-1:0]  b;
  logic [SUM16_W-1:0] sum_int16;
  logic [SUM8_W-1:0]  sum_int8;
  logic [SUM4_W-1:0]  sum_int4;
  logic [SUM2_W-1:0]  sum_int2;

  modport master (
    output a, b,
    input  sum_int16, sum_int8, sum_int4, sum_int2
  );

  modport slave (
    input  a, b,
    output sum_int16, sum_int8, sum_int4, sum_int2
  );

endinterface

// File: rtl/dp64_multiprecision_simd_mul16.sv
// One 16-bit lane: 16x16 product plus summed 8x8, 4x4 and 2x2 sub-products.
// Ports: a, b (16-bit lanes) -> p16, s8, s4, s2 (combinational).
module simd_mul16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p16,
  output logic [16:0] s8,
  output logic [9:0]  s4,
  output logic [6:0]  s2
);

  logic [15:0] p8;
  logic [7:0]  p4;
  logic [3:0]  p2;

  // Operands are zero-extended so every product is full width.
  always_comb begin
    p16 = {16'h0, a} * {16'h0, b};
    s8  = '0;
    s4  = '0;
    s2  = '0;
    p8  = '0;
    p4  = '0;
    p2  = '0;
    for (int i = 0; i < 2; i++) begin
      p8 = {8'h0, a[8*i +: 8]} * {8'h0, b[8*i +: 8]};
      s8 = s8 + {1'b0, p8};
    end
    for (int i = 0; i < 4; i++) begin
      p4 = {4'h0, a[4*i +: 4]} * {4'h0, b[4*i +: 4]};
      s4 = s4 + {2'b0, p4};
    end
    for (int i = 0; i < 8; i++) begin
      p2 = {2'b0, a[2*i +: 2]} * {2'b0, b[2*i +: 2]};
      s2 = s2 + {3'b0, p2};
    end
  end

endmodule

// File: rtl/dp64_multiprecision.sv
// Unsigned dot products of a and b as 16/8/4/2-bit lanes, registered once.
// Ports: CLK, rst (sync, active-high), bus (slave: a, b in; four sums out).
module dp64_multiprecision
  import dp64_multiprecision_pkg::*;
(
  input  logic                  CLK,
  input  logic                  rst,
  dp64_multiprecision_if.slave  bus
);

  logic [31:0] p16 [4];
  logic [16:0] s8  [4];
  logic [9:0]  s4  [4];
  logic [6:0]  s2  [4];

  sums_t nxt;
  sums_t q;

  for (genvar k = 0; k < 4; k++) begin : g_lane
    simd_mul16 u_mul (
      .a   (bus.a[16*k +: 16]),
      .b   (bus.b[16*k +: 16]),
      .p16 (p16[k]),
      .s8  (s8[k]),
      .s4  (s4[k]),
      .s2  (s2[k])
    );
  end

  // Lane sums are widened to the output width before adding.
  always_comb begin
    nxt = '0;
    for (int k = 0; k < 4; k++) begin
      nxt.s16 = nxt.s16 + {3'b0, p16[k]};
      nxt.s8  = nxt.s8  + {2'b0, s8[k]};
      nxt.s4  = nxt.s4  + {2'b0, s4[k]};
      nxt.s2  = nxt.s2  + {4'b0, s2[k]};
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      q <= '0;
    end else begin
      q <= nxt;
    end
  end

  assign bus.sum_int16 = q.s16;
  assign bus.sum_int8  = q.s8;
  assign bus.sum_int4  = q.s4;
  assign bus.sum_int2  = q.s2;

endmodule

// File: tb/tb_dp64_multiprecision.sv
// Self-checking bench for dp64_multiprecision: directed table,
// reset sequences, output hold and random vectors against a lane model.
module tb_dp64_multiprecision;

  logic CLK;
  logic rst;
  int   total;
  int   passed;

  dp64_multiprecision_if bus ();

  dp64_multiprecision dut (
    .CLK (CLK),
    .rst (rst),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] e16;
    logic [63:0] e8;
    logic [63:0] e4;
    logic [63:0] e2;
  } vec_t;

  vec_t tbl [6];

  function automatic logic [63:0] dot(input logic [63:0] x,
                                      input logic [63:0] y,
                                      input int w);
    logic [63:0] acc;
    logic [63:0] m;
    acc = 64'd0;
    m   = (64'd1 << w) - 64'd1;
    for (int k = 0; k < 64 / w; k++)
      acc = acc + (((x >> (w * k)) & m) * ((y >> (w * k)) & m));
    return acc;
  endfunction

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic chk4(input string tag,
                      input logic [63:0] e16, input logic [63:0] e8,
                      input logic [63:0] e4,  input logic [63:0] e2);
    chk({tag, ".sum_int16"}, 64'(bus.sum_int16), e16);
    chk({tag, ".sum_int8"},  64'(bus.sum_int8),  e8);
    chk({tag, ".sum_int4"},  64'(bus.sum_int4),  e4);
    chk({tag, ".sum_int2"},  64'(bus.sum_int2),  e2);
  endtask

  // Drive a pair, take one edge, then look just after it.
  task automatic step(input logic r, input logic [63:0] a,
                      input logic [63:0] b);
    rst   = r;
    bus.a = a;
    bus.b = b;
    @(posedge CLK);
    #1;
  endtask

  logic [63:0] ra;
  logic [63:0] rb;

  initial begin
    total  = 0;
    passed = 0;
    rst    = 1'b1;
    bus.a  = '1;
    bus.b  = '1;

    tbl[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'd17179344900, 64'd520200, 64'd3600, 64'd288};
    tbl[1] = '{64'h0001_0001_0001_0001, 64'h0001_0001_0001_0001,
               64'd4, 64'd4, 64'd4, 64'd4};
    tbl[2] = '{64'h0000_0000_0000_0003, 64'h0000_0000_0000_0002,
               64'd6, 64'd6, 64'd6, 64'd6};
    tbl[3] = '{64'h0000_0000_0000_000F, 64'h0000_0000_0000_00F0,
               64'd3600, 64'd3600, 64'd0, 64'd0};
    tbl[4] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
               64'd1073741824, 64'd16384, 64'd64, 64'd4};
    tbl[5] = '{64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555,
               64'd3817632200, 64'd115600, 64'd800, 64'd64};

    // Reset held two cycles with all-ones operands.
    step(1'b1, '1, '1);
    chk4("rst_c1", 0, 0, 0, 0);
    step(1'b1, '1, '1);
    chk4("rst_c2", 0, 0, 0, 0);

    // Back-to-back table vectors, one per cycle.
    for (int i = 0; i < 6; i++) begin
      step(1'b0, tbl[i].a, tbl[i].b);
      chk4($sformatf("vec%0d", i),
           tbl[i].e16, tbl[i].e8, tbl[i].e4, tbl[i].e2);
    end

    // Output holds between edges while inputs change.
    bus.a = 64'h1234_5678_9ABC_DEF0;
    bus.b = 64'h0FED_CBA9_8765_4321;
    #3;
    chk4("hold", tbl[5].e16, tbl[5].e8, tbl[5].e4, tbl[5].e2);

    // Mid-stream reset discards the in-flight pair.
    step(1'b0, tbl[0].a, tbl[0].b);
    chk4("pre_rst", tbl[0].e16, tbl[0].e8, tbl[0].e4, tbl[0].e2);
    step(1'b1, tbl[5].a, tbl[5].b);
    chk4("mid_rst", 0, 0, 0, 0);
    step(1'b0, tbl[4].a, tbl[4].b);
    chk4("post_rst", tbl[4].e16, tbl[4].e8, tbl[4].e4, tbl[4].e2);

    // Random pairs against the lane model.
    for (int i = 0; i < 40; i++) begin
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      step(1'b0, ra, rb);
      chk4($sformatf("rnd%0d", i),
           dot(ra, rb, 16), dot(ra, rb, 8),
           dot(ra, rb, 4),  dot(ra, rb, 2));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
